// File: rtl/pla_sweep_ctrl.sv
// Exhaustive input sweeper and MISR response compactor for single-output combinational functions.
// Define PLA_SWEEP_SETTLE_EN to hold each vector an extra cycle before it is sampled.
module pla_sweep_ctrl #(
  parameter int              N_IN     = 8,
  parameter int              SIG_W    = 16,
  parameter logic [31:0]     POLY     = 32'h0000_1021,
  parameter logic [SIG_W-1:0] SIG_SEED = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] exp_sig,
  input  logic             y0,
  output logic [N_IN-1:0]  x,
  output logic             busy,
  output logic             done,
  output logic [N_IN:0]    ones_count,
  output logic [SIG_W-1:0] signature,
  output logic             pass
);

`ifdef PLA_SWEEP_SETTLE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, DONE = 2'd2, SETTLE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SAMPLE = 2'd1, DONE = 2'd2} state_t;
`endif

  state_t state, state_nxt;
  logic   last_vec;
  logic   accept;

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s, input logic b);
    misr_step = {s[SIG_W-2:0], 1'b0} ^ (s[SIG_W-1] ? POLY[SIG_W-1:0] : '0)
              ^ {{(SIG_W-1){1'b0}}, b};
  endfunction

  assign last_vec = &x;
  assign accept   = start && !abort;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
`ifdef PLA_SWEEP_SETTLE_EN
        if (accept) state_nxt = SETTLE;
`else
        if (accept) state_nxt = SAMPLE;
`endif
      end
`ifdef PLA_SWEEP_SETTLE_EN
      SETTLE: state_nxt = abort ? IDLE : SAMPLE;
`endif
      SAMPLE: begin
        if (abort)         state_nxt = IDLE;
        else if (last_vec) state_nxt = DONE;
`ifdef PLA_SWEEP_SETTLE_EN
        else               state_nxt = SETTLE;
`else
        else               state_nxt = SAMPLE;
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: vector counter, ON-set count, signature and verdict
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x          <= '0;
      ones_count <= '0;
      signature  <= '0;
      pass       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          x <= '0;
          if (accept) begin
            ones_count <= '0;
            signature  <= SIG_SEED;
            pass       <= 1'b0;
          end
        end
`ifdef PLA_SWEEP_SETTLE_EN
        SETTLE: begin
          if (abort) begin
            x    <= '0;
            pass <= 1'b0;
          end
        end
`endif
        SAMPLE: begin
          if (abort) begin
            // The sample at an aborting edge is dropped; partial results hold.
            x    <= '0;
            pass <= 1'b0;
          end else begin
            ones_count <= ones_count + {{N_IN{1'b0}}, y0};
            signature  <= misr_step(signature, y0);
            if (!last_vec) x <= x + 1'b1;
          end
        end
        DONE: begin
          x    <= '0;
          pass <= abort ? 1'b0 : (signature == exp_sig);
        end
        default: x <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_pla_sweep_ctrl.sv
// Scoreboard bench for pla_sweep_ctrl: directed sweeps, abort, reset and ignored-start cases.
module tb_pla_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] exp_sig;
  logic        y0;
  logic [7:0]  x;
  logic        busy;
  logic        done;
  logic [8:0]  ones_count;
  logic [15:0] signature;
  logic        pass;

  int total = 0;
  int bad   = 0;
  int mode  = 0;
  int done_cnt = 0;
  int bcnt  = 0;

`ifdef PLA_SWEEP_SETTLE_EN
  localparam int BUSY_CYC = 513;
  localparam int PER_VEC  = 2;
`else
  localparam int BUSY_CYC = 257;
  localparam int PER_VEC  = 1;
`endif

  typedef struct {
    logic [8:0]  ones;
    logic [15:0] sig;
    logic        pss;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  pla_sweep_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .exp_sig(exp_sig),
    .y0(y0), .x(x), .busy(busy), .done(done), .ones_count(ones_count),
    .signature(signature), .pass(pass)
  );

  always #5 clk = ~clk;

  function automatic logic fy(input int m, input logic [7:0] v);
    case (m)
      1:       fy = v[0];
      2:       fy = &v;
      3:       fy = 1'b1;
      4:       fy = ~v[0] & ~v[2] & v[1] &
                    ((v[4] & (v[6] == v[7])) ? (v[5] ? v[3] : v[7]) : (~v[3] & v[7] & ~v[5]));
      default: fy = 1'b0;
    endcase
  endfunction

  always_comb y0 = fy(mode, x);

  // Reference: count and compact the first n vectors of function m.
  function automatic void model(input int m, input int n, output logic [8:0] ones,
                                output logic [15:0] sig);
    logic msb;
    logic b;
    ones = '0;
    sig  = 16'hFFFF;
    for (int k = 0; k < n; k++) begin
      b    = fy(m, 8'(k));
      msb  = sig[15];
      sig  = sig << 1;
      if (msb) sig = sig ^ 16'h1021;
      sig[0] = sig[0] ^ b;
      ones = ones + 9'(b);
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals completion.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || !busy) bcnt = 0;
    else                 bcnt++;
    if (rst_n && done) begin
      done_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = sb[0];
        chk("ones_count", 32'(ones_count), 32'(e.ones));
        chk("signature", 32'(signature), 32'(e.sig));
        chk("busy_cycles", 32'(bcnt), 32'(e.cyc));
        bcnt = 0;
        @(negedge clk);
        chk("pass", 32'(pass), 32'(e.pss));
        chk("idle_after_done", 32'(busy), 32'd0);
        void'(sb.pop_front());
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (!busy && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL sweep_timeout busy=%0d pending=%0d required idle", busy, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_sweep(input int m, input logic [8:0] hand_ones, input logic [15:0] flip);
    exp_t        e;
    logic [8:0]  mo;
    logic [15:0] ms;
    model(m, 256, mo, ms);
    e.ones = hand_ones;
    e.sig  = ms;
    e.pss  = (flip == 16'h0);
    e.cyc  = BUSY_CYC;
    sb.push_back(e);
    mode    = m;
    exp_sig = ms ^ flip;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("hold_ones", 32'(ones_count), 32'(hand_ones));
    chk("hold_pass", 32'(pass), 32'(flip == 16'h0));
  endtask

  initial begin
    logic [8:0]  po;
    logic [15:0] ps;
    int          dc;
    rst_n   = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    exp_sig = '0;
    #22;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ones", 32'(ones_count), 32'd0);
    chk("rst_sig", 32'(signature), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_sweep(0, 9'd0,   16'h0000);
    run_sweep(1, 9'd128, 16'h0000);
    run_sweep(2, 9'd1,   16'h0000);
    run_sweep(3, 9'h100, 16'h0000);
    run_sweep(4, 9'd7,   16'h0001);

    // Abort at the edge that would sample vector 100.
    mode = 1;
    dc   = done_cnt;
    model(1, 100, po, ps);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (100 * PER_VEC) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_x", 32'(x), 32'd0);
    chk("abort_ones", 32'(ones_count), 32'(po));
    chk("abort_sig", 32'(signature), 32'(ps));
    chk("abort_pass", 32'(pass), 32'd0);
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(dc));
    run_sweep(2, 9'd1, 16'h0000);

    // start together with abort in IDLE is ignored.
    @(negedge clk) begin start = 1'b1; abort = 1'b1; end
    @(negedge clk) begin start = 1'b0; abort = 1'b0; end
    chk("start_abort_busy", 32'(busy), 32'd0);
    chk("start_abort_ones", 32'(ones_count), 32'd1);
    chk("start_abort_pass", 32'(pass), 32'd1);

    // Asynchronous reset in the middle of a sweep.
    mode = 3;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_x", 32'(x), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_ones", 32'(ones_count), 32'd0);
    chk("mid_rst_sig", 32'(signature), 32'd0);
    chk("mid_rst_pass", 32'(pass), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    run_sweep(0, 9'd0, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
